// File: rtl/pma_region_walker.sv
// pma_region_walker: sequential first-match physical-memory-attribute lookup, one rule per cycle
module pma_region_walker #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned NrRules   = 3,
  parameter int unsigned AttrWidth = 3,
  parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NrRules*AddrWidth-1:0]   rule_base_i,
  input  logic [NrRules*AddrWidth-1:0]   rule_len_i,
  input  logic [NrRules*AttrWidth-1:0]   rule_attr_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AddrWidth-1:0]           req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic                           rsp_hit_o,
  output logic [IdxWidth-1:0]            rsp_idx_o,
  output logic [AttrWidth-1:0]           rsp_attr_o
);
  localparam int unsigned Slots = 2 ** IdxWidth;
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [IdxWidth-1:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 hit_q, hit_d;
  logic [AttrWidth-1:0] attr_q, attr_d;
  logic [AddrWidth-1:0] base_a [Slots];
  logic [AddrWidth-1:0] len_a  [Slots];
  logic [AttrWidth-1:0] attr_a [Slots];
  logic [AddrWidth:0]   end_w;
  logic                 match, last;
  // Unpack the tables; unused power-of-two slots get len 0 so they can never match
  for (genvar g = 0; g < Slots; g++) begin : g_unpack
    if (g < NrRules) begin : g_real
      assign base_a[g] = rule_base_i[g*AddrWidth +: AddrWidth];
      assign len_a[g]  = rule_len_i[g*AddrWidth +: AddrWidth];
      assign attr_a[g] = rule_attr_i[g*AttrWidth +: AttrWidth];
    end else begin : g_pad
      assign base_a[g] = '0;
      assign len_a[g]  = '0;
      assign attr_a[g] = '0;
    end
  end
  assign end_w       = {1'b0, base_a[cnt_q]} + {1'b0, len_a[cnt_q]};
  assign match       = (len_a[cnt_q] != '0) && (addr_q >= base_a[cnt_q]) && ({1'b0, addr_q} < end_w);
  assign last        = cnt_q == IdxWidth'(NrRules - 1);
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_hit_o   = hit_q;
  assign rsp_idx_o   = idx_q;
  assign rsp_attr_o  = attr_q;
  // Next-state: accept in IDLE, walk one rule per cycle in SCAN, hold result in RESP; flush wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    attr_d  = attr_q;
    if (flush_i) begin
      state_d = IDLE;
      hit_d   = 1'b0;
      idx_d   = '0;
      attr_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          state_d = SCAN;
          addr_d  = req_addr_i;
          cnt_d   = '0;
        end
        SCAN: begin
          state_d = (match || last) ? RESP : SCAN;
          cnt_d   = (match || last) ? cnt_q : cnt_q + IdxWidth'(1);
          hit_d   = match;
          idx_d   = match ? cnt_q : '0;
          attr_d  = match ? attr_a[cnt_q] : '0;
        end
        RESP: if (rsp_ready_i) begin
          state_d = IDLE;
          hit_d   = 1'b0;
          idx_d   = '0;
          attr_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // State and result registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      attr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      attr_q  <= attr_d;
    end
  end
endmodule
